// File: rtl/washer_ctrl_param.sv
// -----------------------------------------------------------------------------
// washer_ctrl_param
//
// Coin-operated washing-machine sequencer.  Coins build credit toward PRICE;
// once paid and with the lid closed, a run goes SOAK -> (WASH -> RINSE) x
// (1 + extra pairs) -> SPIN -> IDLE.  Each phase lasts T_* ticks of the external
// tick enable.  If the lid opens in any running phase, the controller parks in
// PAUSE with the phase timer frozen.  When the lid closes, it resumes the same
// phase without reloading the timer.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   tick         one-cycle timebase enable; timers only advance on tick
//   moeda        coin pulse, one cycle per coin
//   lid_r        1 = lid open
//   d_lavar[1:0] extra wash/rinse pairs requested, sampled at start
//   molho        soak valve          (state SOAK)
//   lavar        wash agitation      (state WASH)
//   enxague      rinse               (state RINSE)
//   centrifugar  spin motor          (state SPIN)
//   pausar       paused indicator    (state PAUSE)
//   brake        spin brake          (PAUSE entered from SPIN)
//                "break" is a reserved word in SystemVerilog, so the brake
//                driver output carries this name instead.
//   busy         any state other than IDLE
//   done         one-cycle pulse in the first IDLE cycle after SPIN
//   credit[CW-1:0] current coin credit
//
// Optional build macro WASHER_STATUS_EN adds:
//   phase[2:0]       state code (IDLE=0 SOAK=1 WASH=2 RINSE=3 SPIN=4 PAUSE=5)
//   remaining[TW-1:0] live phase timer, frozen value while in PAUSE
// -----------------------------------------------------------------------------
module washer_ctrl_param #(
    parameter int TW        = 8,
    parameter int T_SOAK    = 10,
    parameter int T_WASH    = 20,
    parameter int T_RINSE   = 15,
    parameter int T_SPIN    = 12,
    parameter int PRICE     = 2,
    parameter int CW        = 4,
    parameter int MAX_EXTRA = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          moeda,
    input  logic          lid_r,
    input  logic [1:0]    d_lavar,
    output logic          molho,
    output logic          lavar,
    output logic          enxague,
    output logic          centrifugar,
    output logic          pausar,
    output logic          brake,
    output logic          busy,
    output logic          done,
`ifdef WASHER_STATUS_EN
    output logic [2:0]    phase,
    output logic [TW-1:0] remaining,
`endif
    output logic [CW-1:0] credit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SOAK  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    localparam logic [TW-1:0] T_SOAK_C  = TW'(T_SOAK);
    localparam logic [TW-1:0] T_WASH_C  = TW'(T_WASH);
    localparam logic [TW-1:0] T_RINSE_C = TW'(T_RINSE);
    localparam logic [TW-1:0] T_SPIN_C  = TW'(T_SPIN);
    localparam logic [TW-1:0] ONE_C     = TW'(1);
    localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
    localparam logic [1:0]    MAX_C     = 2'(MAX_EXTRA);

    state_t        state;
    state_t        saved;    // phase to resume after PAUSE
    logic [TW-1:0] cnt;
    logic [1:0]    rem;      // wash/rinse pairs still to repeat
    logic          start;

    // Coin accounting.  On a start cycle the price is taken out of the credit
    // plus any coin arriving in that same cycle.  Credit >= PRICE there, so the
    // subtraction cannot underflow.  PRICE >= 1, so the result also fits even
    // when a coin lands on a full counter.
    function automatic logic [CW-1:0] credit_next_f(input logic [CW-1:0] c,
                                                    input logic          coin,
                                                    input logic          take);
        logic [CW:0] sum;
        sum = {1'b0, c} + {{CW{1'b0}}, coin};
        if (take)
            sum = sum - {1'b0, PRICE_C};
        else if (sum[CW])
            sum = {1'b0, {CW{1'b1}}};
        return sum[CW-1:0];
    endfunction

    assign start = (state == IDLE) && (credit >= PRICE_C) && !lid_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            saved  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            credit <= '0;
            done   <= 1'b0;
        end else begin
            credit <= credit_next_f(credit, moeda, start);
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SOAK;
                        cnt   <= T_SOAK_C;
                        rem   <= (d_lavar > MAX_C) ? MAX_C : d_lavar;
                    end
                end
                SOAK, WASH, RINSE, SPIN: begin
                    // An open lid takes priority over a terminal tick.  The
                    // timer stays at 1, so the phase ends on the first tick
                    // after resume.
                    if (lid_r) begin
                        state <= PAUSE;
                        saved <= state;
                    end else if (tick) begin
                        if (cnt > ONE_C) begin
                            cnt <= cnt - ONE_C;
                        end else begin
                            case (state)
                                SOAK: begin
                                    state <= WASH;
                                    cnt   <= T_WASH_C;
                                end
                                WASH: begin
                                    state <= RINSE;
                                    cnt   <= T_RINSE_C;
                                end
                                RINSE: begin
                                    if (rem != 2'd0) begin
                                        state <= WASH;
                                        cnt   <= T_WASH_C;
                                        rem   <= rem - 2'd1;
                                    end else begin
                                        state <= SPIN;
                                        cnt   <= T_SPIN_C;
                                    end
                                end
                                default: begin
                                    state <= IDLE;
                                    cnt   <= '0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                PAUSE: begin
                    // Ticks are ignored here, and the timer is not reloaded.
                    if (!lid_r)
                        state <= saved;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    rem   <= '0;
                end
            endcase
        end
    end

    // Output decode of the registered state
    assign molho       = (state == SOAK);
    assign lavar       = (state == WASH);
    assign enxague     = (state == RINSE);
    assign centrifugar = (state == SPIN);
    assign pausar      = (state == PAUSE);
    assign brake       = (state == PAUSE) && (saved == SPIN);
    assign busy        = (state != IDLE);

`ifdef WASHER_STATUS_EN
    assign phase     = state;
    assign remaining = cnt;
`endif

endmodule

// File: tb/tb_washer_ctrl_param.sv
module tb_washer_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       moeda = 1'b0;
    logic       lid_r = 1'b0;
    logic [1:0] d_lavar = 2'd0;
    logic       molho, lavar, enxague, centrifugar, pausar, brake, busy, done;
    logic [3:0] credit;
`ifdef WASHER_STATUS_EN
    logic [2:0] phase;
    logic [7:0] remaining;
`endif

    logic [7:0]  outv;
    logic [11:0] exp_v;
    logic [11:0] sb[$];   // {credit, molho,lavar,enxague,centrifugar,pausar,brake,busy,done}
    int checks = 0;
    int errors = 0;

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_SOAK  = 8'b1000_0010;
    localparam logic [7:0] O_WASH  = 8'b0100_0010;
    localparam logic [7:0] O_RINSE = 8'b0010_0010;
    localparam logic [7:0] O_SPIN  = 8'b0001_0010;
    localparam logic [7:0] O_PAUSE = 8'b0000_1010;
    localparam logic [7:0] O_PBRK  = 8'b0000_1110;
    localparam logic [7:0] O_DONE  = 8'b0000_0001;

    washer_ctrl_param #(
        .TW(8), .T_SOAK(2), .T_WASH(3), .T_RINSE(2), .T_SPIN(2),
        .PRICE(2), .CW(4), .MAX_EXTRA(3)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .moeda(moeda), .lid_r(lid_r),
        .d_lavar(d_lavar), .molho(molho), .lavar(lavar), .enxague(enxague),
        .centrifugar(centrifugar), .pausar(pausar), .brake(brake), .busy(busy),
        .done(done),
`ifdef WASHER_STATUS_EN
        .phase(phase), .remaining(remaining),
`endif
        .credit(credit)
    );

    always #5 clk = ~clk;

    assign outv = {molho, lavar, enxague, centrifugar, pausar, brake, busy, done};

    // Expected-value model: push n cycles of a given output pattern and credit.
    task automatic push(input logic [7:0] o, input int n, input logic [3:0] cr);
        for (int i = 0; i < n; i++) sb.push_back({cr, o});
    endtask

    // Plain run with d extra pairs, timing from the bench parameters.
    task automatic push_run(input int d, input logic [3:0] cr);
        push(O_SOAK, 2, cr);
        for (int p = 0; p <= d; p++) begin
            push(O_WASH, 3, cr);
            push(O_RINSE, 2, cr);
        end
        push(O_SPIN, 2, cr);
        push(O_DONE, 1, cr);
    endtask

    task automatic insert_coins(input int n);
        for (int i = 0; i < n; i++) begin
            moeda = 1'b1;
            @(posedge clk); #1;
            moeda = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({credit, outv} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", {credit, outv}, 12'h000);
        end
        reset = 1'b0;
    endtask

    task automatic test_coin_start;
        d_lavar = 2'd0;
        insert_coins(1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({credit, outv} !== {4'd1, O_IDLE}) begin
                errors++;
                $display("FAIL one_coin_idle cyc=%0d got %h expected %h", i, {credit, outv}, {4'd1, O_IDLE});
            end
        end
        insert_coins(1);
        checks++;
        if ({credit, outv} !== {4'd2, O_IDLE}) begin
            errors++;
            $display("FAIL second_coin got %h expected %h", {credit, outv}, {4'd2, O_IDLE});
        end
        push_run(0, 4'd0);
        push(O_IDLE, 1, 4'd0);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL single_run cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
    endtask

    task automatic test_extra_pairs;
        int busy_cnt;
        busy_cnt = 0;
        d_lavar = 2'd2;
        insert_coins(2);
        push_run(2, 4'd0);
        // one coin dropped during the run adds credit from that edge onward
        for (int i = 5; i < sb.size(); i++) sb[i][11:8] = 4'd1;
        for (int c = 0; sb.size() > 0; c++) begin
            moeda = (c == 5);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            if (busy) busy_cnt++;
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL extra_pairs cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
        moeda = 1'b0;
        checks++;
        if (busy_cnt !== 19) begin
            errors++;
            $display("FAIL extra_pairs_busy got %0d expected %0d", busy_cnt, 19);
        end
        d_lavar = 2'd0;
    endtask

    task automatic test_pause;
        // Lid opens on the last spin cycle, for 5 edges.
        insert_coins(1);   // credit was 1
        push(O_SOAK, 2, 4'd0); push(O_WASH, 3, 4'd0); push(O_RINSE, 2, 4'd0);
        push(O_SPIN, 2, 4'd0); push(O_PBRK, 5, 4'd0); push(O_SPIN, 1, 4'd0);
        push(O_DONE, 1, 4'd0);
        for (int c = 0; sb.size() > 0; c++) begin
            lid_r = (c >= 9 && c <= 13);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL pause_spin cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
        lid_r = 1'b0;
        // Lid opens in the first wash cycle: no brake, and the timer is frozen.
        insert_coins(2);
        push(O_SOAK, 2, 4'd0); push(O_WASH, 1, 4'd0); push(O_PAUSE, 3, 4'd0);
        push(O_WASH, 3, 4'd0); push(O_RINSE, 2, 4'd0); push(O_SPIN, 2, 4'd0);
        push(O_DONE, 1, 4'd0);
        for (int c = 0; sb.size() > 0; c++) begin
            lid_r = (c >= 3 && c <= 5);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL pause_wash cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
        lid_r = 1'b0;
    endtask

    task automatic test_terminal_lid;
        // Two tick-less cycles stretch SOAK.  The lid opens on the terminal
        // wash tick.
        insert_coins(2);
        push(O_SOAK, 4, 4'd0); push(O_WASH, 3, 4'd0); push(O_PAUSE, 2, 4'd0);
        push(O_WASH, 1, 4'd0); push(O_RINSE, 2, 4'd0); push(O_SPIN, 2, 4'd0);
        push(O_DONE, 1, 4'd0);
        for (int c = 0; sb.size() > 0; c++) begin
            tick  = !(c == 1 || c == 2);
            lid_r = (c == 7 || c == 8);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL terminal_lid cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
        tick  = 1'b1;
        lid_r = 1'b0;
    endtask

    task automatic test_saturation_back_to_back;
        lid_r = 1'b1;
        moeda = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({credit, outv} !== {((i > 15) ? 4'd15 : 4'(i)), O_IDLE}) begin
                errors++;
                $display("FAIL saturate coin=%0d got %h expected %h", i, {credit, outv},
                         {((i > 15) ? 4'd15 : 4'(i)), O_IDLE});
            end
        end
        moeda = 1'b0;
        lid_r = 1'b0;
        push_run(0, 4'd13);
        push(O_SOAK, 2, 4'd11);   // back-to-back start right after done
        push(O_WASH, 1, 4'd11);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({credit, outv} !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got %h expected %h", c, {credit, outv}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({credit, outv} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_wash got %h expected %h", {credit, outv}, 12'h000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({credit, outv} !== 12'h000) begin
                errors++;
                $display("FAIL after_reset_idle cyc=%0d got %h expected %h", i, {credit, outv}, 12'h000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coin_start();
        test_extra_pairs();
        test_pause();
        test_terminal_lid();
        test_saturation_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/washer_ctrl_param.md
Name: washer_ctrl_param

Overview:
Parametrised coin-operated washing-machine sequencer, next generation of the fixed single/double-wash controller.
- Internal per-phase timers replace the external Tempo strobe.
- Coin credit accumulates toward a configurable price.
- Wash/rinse pairs repeat a run-time-selected number of times.
- Lid-open pause is legal in any running phase and resumes with the remaining time preserved.
- Sits between the coin acceptor / lid sensor / tick prescaler and the motor, valve and brake drivers.

Parameters:
TW, 8, timer width in bits; every T_* must be in 1..2^TW-1
T_SOAK, 10, soak duration in ticks
T_WASH, 20, wash duration in ticks
T_RINSE, 15, rinse duration in ticks
T_SPIN, 12, spin duration in ticks
PRICE, 2, coins consumed per run (1..2^CW-1)
CW, 4, credit counter width
MAX_EXTRA, 3, maximum extra wash/rinse pairs (0..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle timebase enable; timers advance only when tick=1
moeda  in  1  coin pulse, one cycle per coin
lid_r  in  1  1 = lid open
d_lavar  in  2  extra wash/rinse pairs requested; sampled at start
molho  out  1  soak valve
lavar  out  1  wash agitation
enxague  out  1  rinse
centrifugar  out  1  spin motor
pausar  out  1  paused indicator
break  out  1  spin brake
busy  out  1  run in progress (any state except IDLE)
done  out  1  one-cycle pulse at end of run
credit  out  CW  current coin credit

Behaviour:
- States: IDLE, SOAK, WASH, RINSE, SPIN, PAUSE. The state, saved phase, timer cnt, remaining-pairs counter rem and credit are all registered.
- Outputs are a pure decode of registered state: molho=SOAK, lavar=WASH, enxague=RINSE, centrifugar=SPIN, pausar=PAUSE, break=PAUSE with saved phase SPIN, busy=state≠IDLE. Exactly one of molho/lavar/enxague/centrifugar/pausar is high outside IDLE.
- Reset, at any time including mid-run: state=IDLE, credit=0, cnt=0, rem=0, done=0. All outputs are 0 on the next cycle.
- Credit:
  - Each moeda=1 cycle adds 1, saturating at 2^CW-1.
  - Coins are accepted in every state.
  - On the start cycle, credit_next = credit + moeda - PRICE.
- Start: in IDLE, if registered credit ≥ PRICE and lid_r=0, go to SOAK. In the same cycle load cnt=T_SOAK and rem=min(d_lavar, MAX_EXTRA).
- If lid_r=1 in IDLE, stay in IDLE; credit is kept.
- Phase timing:
  - On entry to a phase, cnt is loaded with that phase's T_*.
  - tick=1 and cnt>1: cnt decrements.
  - tick=1 and cnt==1: the phase ends. Each phase therefore lasts exactly T_* ticks.
- Phase sequence:
  - SOAK→WASH.
  - WASH→RINSE.
  - RINSE→WASH if rem>0 (rem decrements), otherwise RINSE→SPIN.
  - SPIN→IDLE, with done=1 for that single cycle.
- Pause:
  - lid_r=1 in SOAK/WASH/RINSE/SPIN: go to PAUSE, save the phase, freeze cnt.
  - Ticks are ignored while in PAUSE.
  - lid_r=0 in PAUSE: return to the saved phase with the frozen cnt, with no reload.
  - If lid opens in the same cycle as a terminal tick, the lid wins: go to PAUSE with cnt=1, and the phase completes on the first tick after resume.
- Coins during a run only add credit. A back-to-back run starts from IDLE on the cycle after done if credit ≥ PRICE.
- Illegal state encoding: recover to IDLE on the next clock.

Optional Feature:
WASHER_STATUS_EN
- Defined: adds output phase[2:0] (IDLE=0, SOAK=1, WASH=2, RINSE=3, SPIN=4, PAUSE=5) and output remaining[TW-1:0], which is the live cnt and shows the frozen value in PAUSE.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
Bench parameters: T_SOAK=2, T_WASH=3, T_RINSE=2, T_SPIN=2, PRICE=2, CW=4, tick held at 1 unless stated.
1. Single coin, then wait 20 cycles -> credit=1, state stays IDLE, all outputs 0. Second coin -> credit=2; next cycle busy=1, molho=1, credit=0.
2. Start with d_lavar=0 -> molho 2 cycles, lavar 3, enxague 2, centrifugar 2, then done=1 for one cycle, busy=0.
3. Start with d_lavar=2 -> phase order SOAK, (WASH, RINSE)×3, SPIN. Total busy time 2+15+2=19 cycles.
4. lid_r=1 for 5 cycles at the 2nd spin cycle -> pausar=1 and break=1 for 5 cycles, then centrifugar resumes for 1 more tick. Same test during WASH -> break=0 while paused.
5. 20 coins in IDLE with lid_r=1 -> credit saturates at 15, no start. Lid closes -> run starts, credit=13.
6. reset pulse mid-WASH -> next cycle all outputs 0, credit=0. Test lid opening on a terminal tick -> PAUSE entered, phase does not advance until after resume.
